muldiv_sequencer: RTL and testbench
===================================

# muldiv_sequencer

Control stage directly upstream of the pipelined multiply/divide unit (`alu_mult_div`) in the ao68000 ALU. It accepts one MULU/MULS/DIVU/DIVS request and drives and holds the operands into the unit. It waits the unit's fixed pipeline latency, then captures the matching result and forms the 68000 result word and N/Z/V/C flags. It also detects divide-by-zero before launching.

## Interface
- `MUL_LATENCY`, 18, pipeline depth of the multiplier paths
- `DIV_LATENCY`, 30, pipeline depth of the divider paths
- `clock` in 1: single clock; all logic on rising edge
- `reset` in 1: asynchronous, active-low (asserted when 0)
- `start` in 1: request strobe, sampled in IDLE only
- `op` in 2: 00 MULU, 01 MULS, 10 DIVU, 11 DIVS
- `src_a` in 32: destination Dn (dividend or 16-bit multiplicand in [15:0])
- `src_b` in 16: source word (divisor or multiplier)
- `operand1` out 32: to the multiply/divide unit, held while busy
- `operand2` out 32: to the multiply/divide unit, {16'b0, src_b}, held while busy
- `divu_quotient` in 32, `divu_remainder` in 16: from the multiply/divide unit
- `divs_quotient` in 32, `divs_remainder` in 16: from the multiply/divide unit
- `mulu_result` in 32, `muls_result` in 32: from the multiply/divide unit
- `busy` out 1: operation in flight
- `done` out 1: one-cycle pulse; `result` and flags valid
- `result` out 32: 68000 destination value
- `flag_n`, `flag_z`, `flag_v`, `flag_c` out 1 each
- `div_zero` out 1: one-cycle trap pulse
- `abort` in 1: present only with `MULDIV_ABORT_EN`

## Operation
- States: IDLE and RUN. Reset forces IDLE. All outputs reset to 0.
- IDLE with `start`=1 and DIV op with `src_b`==0:
  - `div_zero` pulses next cycle.
  - No launch; state stays IDLE; `busy` stays 0; `result` and flags unchanged.
- IDLE with `start`=1, otherwise:
  - Register `operand1`=`src_a`, `operand2`={16'b0,`src_b`}, and the op.
  - Load the counter with the op's latency; go to RUN; `busy`=1.
- RUN: counter decrements each cycle. When it reaches 0, capture and evaluate the result, pulse `done`, and return to IDLE.
- `start` while RUN is ignored, with no queueing.
- MULU/MULS:
  - `result` = `mulu_result` or `muls_result`.
  - N=result[31], Z=(result==0), V=0, C=0.
- DIVU:
  - Overflow when `divu_quotient`[31:16]!=0.
  - DIVS overflow when `divs_quotient`[31:15] is not all-equal.
  - No overflow: `result`={remainder, quotient[15:0]}, N=quotient[15], Z=(quotient[15:0]==0), V=0, C=0.
  - Overflow: `result`=`operand1` (destination unchanged), V=1, N=0, Z=0, C=0.
- `reset` asserted mid-operation: immediate return to IDLE, outputs 0, and any in-flight result is discarded.

## Timing
- Edge 0 samples `start`. `operand1`/`operand2`/`busy` are valid from edge 0.
- `done` is high in the cycle after edge LAT+1, where LAT is `MUL_LATENCY` or `DIV_LATENCY`. This gives 19 cycles for MUL and 31 for DIV.
- `busy` falls in the same cycle `done` rises.
- A new `start` is accepted during the `done` cycle, so back-to-back operations are allowed.
- `div_zero` is high in the cycle after edge 0.
- `result` and flags hold until the next `done`.

## Configuration
- `MULDIV_ABORT_EN` defined:
  - Adds the `abort` input.
  - `abort`=1 in RUN returns to IDLE at the next edge, with no `done`, and `result`/flags unchanged.
  - `abort` in IDLE has no effect.
  - Simultaneous `abort` and the final count: abort wins.
- Not defined: no `abort` port; every launched op completes.

## Structure
- Package `muldiv_pkg` holds:
  - op encodings (MULU/MULS/DIVU/DIVS)
  - the state enum (IDLE, RUN)
  - default latency constants
  - counter width = clog2(max latency + 1)
- Sub-module `muldiv_flags`: combinational overflow detection, result packing and N/Z/V/C from op, operand1 and the unit's outputs.

## Test plan
- MULU, `src_a`=0x00000003, `src_b`=0x0004 -> `done` at cycle 19, `result`=0x0000000C, NZVC=0000.
- MULS, `src_a`=0x0000FFFF, `src_b`=0x0002 -> `result`=0xFFFFFFFE, N=1, Z=0, V=0.
- DIVU 100/7 -> `done` at cycle 31, `result`=0x0002000E, NZVC=0000.
- DIVS, `src_a`=0xFFFFFFF9, `src_b`=0x0002 -> `result`=0xFFFFFFFD, N=1.
- DIVU, `src_a`=0x00100000, `src_b`=0x0001 -> V=1, `result`=0x00100000.
- DIVU with `src_b`=0 -> `div_zero` pulse at cycle 1, `busy` never 1.
- `reset` low at cycle 10 of a DIV -> `busy`=0 and no `done`.
- With `MULDIV_ABORT_EN`: `abort` at cycle 5 -> no `done`.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the muldiv sequencer: op encodings, FSM states,
// default pipeline latencies and the latency counter width.
package muldiv_pkg;

    typedef enum logic [1:0] {
        MULU = 2'b00,
        MULS = 2'b01,
        DIVU = 2'b10,
        DIVS = 2'b11
    } op_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int OP_W            = 2;
    localparam int MUL_LATENCY_DEF = 18;
    localparam int DIV_LATENCY_DEF = 30;

    function automatic int cnt_width(input int mulLat, input int divLat);
        return $clog2(((mulLat > divLat) ? mulLat : divLat) + 1);
    endfunction

    localparam int CNT_W = cnt_width(MUL_LATENCY_DEF, DIV_LATENCY_DEF);

    function automatic logic is_div(input op_e op);
        return op[1];
    endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Request/response and multiply/divide unit signals of the muldiv sequencer.
// MULDIV_ABORT_EN adds the abort request line.
interface muldiv_sequencer_if;
    import muldiv_pkg::*;

    logic            start;
    logic [OP_W-1:0] op;
    logic [31:0]     src_a;
    logic [15:0]     src_b;
    logic [31:0]     operand1;
    logic [31:0]     operand2;
    logic [31:0]     divu_quotient;
    logic [15:0]     divu_remainder;
    logic [31:0]     divs_quotient;
    logic [15:0]     divs_remainder;
    logic [31:0]     mulu_result;
    logic [31:0]     muls_result;
    logic            busy;
    logic            done;
    logic [31:0]     result;
    logic            flag_n;
    logic            flag_z;
    logic            flag_v;
    logic            flag_c;
    logic            div_zero;

    modport unit (
        input  operand1, operand2,
        output divu_quotient, divu_remainder, divs_quotient, divs_remainder,
               mulu_result, muls_result
    );

`ifdef MULDIV_ABORT_EN
    logic abort;

    modport master (
        output start, op, src_a, src_b, abort,
        input  busy, done, result, flag_n, flag_z, flag_v, flag_c, div_zero
    );

    modport slave (
        input  start, op, src_a, src_b, abort,
               divu_quotient, divu_remainder, divs_quotient, divs_remainder,
               mulu_result, muls_result,
        output operand1, operand2, busy, done, result,
               flag_n, flag_z, flag_v, flag_c, div_zero
    );
`else
    modport master (
        output start, op, src_a, src_b,
        input  busy, done, result, flag_n, flag_z, flag_v, flag_c, div_zero
    );

    modport slave (
        input  start, op, src_a, src_b,
               divu_quotient, divu_remainder, divs_quotient, divs_remainder,
               mulu_result, muls_result,
        output operand1, operand2, busy, done, result,
               flag_n, flag_z, flag_v, flag_c, div_zero
    );
`endif

endinterface

// File: rtl/muldiv_flags.sv
// Combinational result packing, divide overflow detection and N/Z/V/C
// generation from the multiply/divide unit outputs.
module muldiv_flags
    import muldiv_pkg::*;
(
    input  op_e         op_i,
    input  logic [31:0] operand1_i,
    input  logic [31:0] divuQuotient_i,
    input  logic [15:0] divuRemainder_i,
    input  logic [31:0] divsQuotient_i,
    input  logic [15:0] divsRemainder_i,
    input  logic [31:0] muluResult_i,
    input  logic [31:0] mulsResult_i,
    output logic [31:0] result_o,
    output logic [3:0]  nzvc_o
);

    logic divuOvf;
    logic divsOvf;

    assign divuOvf = |divuQuotient_i[31:16];
    // A signed quotient fits in 16 bits only if bits 31..15 are pure sign extension.
    assign divsOvf = !((&divsQuotient_i[31:15]) || !(|divsQuotient_i[31:15]));

    always_comb begin
        result_o = 32'h0;
        nzvc_o   = 4'b0000;
        case (op_i)
            MULU: begin
                result_o = muluResult_i;
                nzvc_o   = {muluResult_i[31], muluResult_i == 32'h0, 2'b00};
            end
            MULS: begin
                result_o = mulsResult_i;
                nzvc_o   = {mulsResult_i[31], mulsResult_i == 32'h0, 2'b00};
            end
            DIVU: begin
                if (divuOvf) begin
                    result_o = operand1_i;
                    nzvc_o   = 4'b0010;
                end else begin
                    result_o = {divuRemainder_i, divuQuotient_i[15:0]};
                    nzvc_o   = {divuQuotient_i[15], divuQuotient_i[15:0] == 16'h0, 2'b00};
                end
            end
            DIVS: begin
                if (divsOvf) begin
                    result_o = operand1_i;
                    nzvc_o   = 4'b0010;
                end else begin
                    result_o = {divsRemainder_i, divsQuotient_i[15:0]};
                    nzvc_o   = {divsQuotient_i[15], divsQuotient_i[15:0] == 16'h0, 2'b00};
                end
            end
            default: begin
                result_o = 32'h0;
                nzvc_o   = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Launches one MULU/MULS/DIVU/DIVS into the pipelined mult/div unit, waits its
// latency and registers the 68000 result and flags. MULDIV_ABORT_EN adds abort.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int MUL_LATENCY = MUL_LATENCY_DEF,
    parameter int DIV_LATENCY = DIV_LATENCY_DEF
)
(
    input logic               clock,
    input logic               reset,
    muldiv_sequencer_if.slave bus
);

    localparam int ReqW = cnt_width(MUL_LATENCY, DIV_LATENCY);
    localparam int CntW = (ReqW > CNT_W) ? ReqW : CNT_W;

    state_e            state_q,    state_d;
    logic [CntW-1:0]   count_q,    count_d;
    op_e               op_q,       op_d;
    logic [31:0]       operand1_q, operand1_d;
    logic [31:0]       operand2_q, operand2_d;
    logic [31:0]       result_q,   result_d;
    logic [3:0]        nzvc_q,     nzvc_d;
    logic              done_q,     done_d;
    logic              divZero_q,  divZero_d;

    op_e               reqOp;
    logic [31:0]       flagResult;
    logic [3:0]        flagNzvc;
    logic              abortReq;

    assign reqOp = op_e'(bus.op);

`ifdef MULDIV_ABORT_EN
    assign abortReq = bus.abort;
`else
    assign abortReq = 1'b0;
`endif

    muldiv_flags u_flags (
        .op_i            (op_q),
        .operand1_i      (operand1_q),
        .divuQuotient_i  (bus.divu_quotient),
        .divuRemainder_i (bus.divu_remainder),
        .divsQuotient_i  (bus.divs_quotient),
        .divsRemainder_i (bus.divs_remainder),
        .muluResult_i    (bus.mulu_result),
        .mulsResult_i    (bus.muls_result),
        .result_o        (flagResult),
        .nzvc_o          (flagNzvc)
    );

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        op_d       = op_q;
        operand1_d = operand1_q;
        operand2_d = operand2_q;
        result_d   = result_q;
        nzvc_d     = nzvc_q;
        done_d     = 1'b0;
        divZero_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (is_div(reqOp) && (bus.src_b == 16'h0)) begin
                        divZero_d = 1'b1;
                    end else begin
                        state_d    = RUN;
                        op_d       = reqOp;
                        operand1_d = bus.src_a;
                        operand2_d = {16'h0, bus.src_b};
                        count_d    = is_div(reqOp) ? CntW'(DIV_LATENCY) : CntW'(MUL_LATENCY);
                    end
                end
            end
            RUN: begin
                // Abort takes priority even over the final count so no result escapes.
                if (abortReq) begin
                    state_d = IDLE;
                end else if (count_q == '0) begin
                    state_d  = IDLE;
                    done_d   = 1'b1;
                    result_d = flagResult;
                    nzvc_d   = flagNzvc;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            count_q    <= '0;
            op_q       <= MULU;
            operand1_q <= 32'h0;
            operand2_q <= 32'h0;
            result_q   <= 32'h0;
            nzvc_q     <= 4'b0000;
            done_q     <= 1'b0;
            divZero_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            op_q       <= op_d;
            operand1_q <= operand1_d;
            operand2_q <= operand2_d;
            result_q   <= result_d;
            nzvc_q     <= nzvc_d;
            done_q     <= done_d;
            divZero_q  <= divZero_d;
        end
    end

    assign bus.operand1 = operand1_q;
    assign bus.operand2 = operand2_q;
    assign bus.busy     = (state_q == RUN);
    assign bus.done     = done_q;
    assign bus.result   = result_q;
    assign bus.flag_n   = nzvc_q[3];
    assign bus.flag_z   = nzvc_q[2];
    assign bus.flag_v   = nzvc_q[1];
    assign bus.flag_c   = nzvc_q[0];
    assign bus.div_zero = divZero_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer with an arithmetic reference model
// and a cycle-exact model of the mult/div unit. MULDIV_ABORT_EN adds abort tests.
module tb_muldiv_sequencer;

    localparam int MUL_LAT = 18;
    localparam int DIV_LAT = 30;

    logic clock;
    logic reset;
    int   checks = 0;
    int   passed = 0;
    logic [31:0] prevRes;
    logic [3:0]  prevFlags;

    muldiv_sequencer_if bus();

    muldiv_sequencer dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // 68000 result and NZVC from plain arithmetic on the original operands.
    function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [15:0] b,
                                  output logic [31:0] res, output logic [3:0] nzvc);
        longint x, y, q, r, p;
        bit ovf;
        res  = 32'h0;
        nzvc = 4'b0000;
        ovf  = 1'b0;
        q    = 0;
        r    = 0;
        case (op)
            2'b00, 2'b01: begin
                if (op == 2'b00) begin
                    x = {48'h0, a[15:0]};
                    y = {48'h0, b};
                end else begin
                    x = longint'($signed(a[15:0]));
                    y = longint'($signed(b));
                end
                p    = x * y;
                res  = 32'(p);
                nzvc = {res[31], res == 32'h0, 2'b00};
            end
            default: begin
                if (op == 2'b10) begin
                    x   = {32'h0, a};
                    y   = {48'h0, b};
                    q   = x / y;
                    r   = x % y;
                    ovf = (q > 65535);
                end else begin
                    x   = longint'($signed(a));
                    y   = longint'($signed(b));
                    q   = x / y;
                    r   = x % y;
                    ovf = (q > 32767) || (q < -32768);
                end
                if (ovf) begin
                    res  = a;
                    nzvc = 4'b0010;
                end else begin
                    res  = {16'(r), 16'(q)};
                    nzvc = {q[15], 16'(q) == 16'h0, 2'b00};
                end
            end
        endcase
    endfunction

    // Unit outputs are correct only in the cycle the sequencer should capture them.
    task automatic driveUnit(input logic [31:0] a, input logic [15:0] b, input bit valid);
        longint ua, ub, sa, sb;
        if (!valid) begin
            bus.divu_quotient  = $urandom;
            bus.divu_remainder = 16'($urandom);
            bus.divs_quotient  = $urandom;
            bus.divs_remainder = 16'($urandom);
            bus.mulu_result    = $urandom;
            bus.muls_result    = $urandom;
        end else begin
            ua = {48'h0, a[15:0]};
            ub = {48'h0, b};
            sa = longint'($signed(a[15:0]));
            sb = longint'($signed(b));
            bus.mulu_result = 32'(ua * ub);
            bus.muls_result = 32'(sa * sb);
            ua = {32'h0, a};
            sa = longint'($signed(a));
            if (b != 16'h0) begin
                bus.divu_quotient  = 32'(ua / ub);
                bus.divu_remainder = 16'(ua % ub);
                bus.divs_quotient  = 32'(sa / sb);
                bus.divs_remainder = 16'(sa % sb);
            end
        end
    endtask

    task automatic runOp(input logic [1:0] op, input logic [31:0] a, input logic [15:0] b,
                         input bit pokeStart, input string name);
        logic [31:0] expRes;
        logic [3:0]  expFlags;
        int          lat;
        bit          bad;
        model(op, a, b, expRes, expFlags);
        lat = op[1] ? DIV_LAT : MUL_LAT;
        bus.start = 1'b1;
        bus.op    = op;
        bus.src_a = a;
        bus.src_b = b;
        driveUnit(a, b, 1'b0);
        @(posedge clock); #1;
        bus.start = 1'b0;
        bus.src_a = $urandom;
        bus.src_b = 16'($urandom);
        checks++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.operand1 !== a || bus.operand2 !== {16'h0, b})
            $display("[TB] FAIL %s launch: busy=%b done=%b op1=%h op2=%h, expected busy=1 done=0 op1=%h op2=%h",
                     name, bus.busy, bus.done, bus.operand1, bus.operand2, a, {16'h0, b});
        else passed++;
        bad = 1'b0;
        for (int k = 1; k <= lat; k++) begin
            @(posedge clock); #1;
            if (bus.done !== 1'b0 || bus.busy !== 1'b1 || bus.div_zero !== 1'b0 || bus.operand1 !== a) bad = 1'b1;
            if (pokeStart && k == 3) begin
                bus.start = 1'b1;
                bus.op    = 2'b10;
                bus.src_b = 16'h0;
            end
            if (k == 4) bus.start = 1'b0;
            if (k == lat / 2) begin
                checks++;
                if (bus.result !== prevRes || {bus.flag_n, bus.flag_z, bus.flag_v, bus.flag_c} !== prevFlags)
                    $display("[TB] FAIL %s hold: result=%h nzvc=%b, expected result=%h nzvc=%b", name,
                             bus.result, {bus.flag_n, bus.flag_z, bus.flag_v, bus.flag_c}, prevRes, prevFlags);
                else passed++;
            end
        end
        checks++;
        if (bad) $display("[TB] FAIL %s run: early done, dropped busy or relaunch seen, expected steady busy for %0d cycles", name, lat);
        else passed++;
        driveUnit(a, b, 1'b1);
        @(posedge clock); #1;
        driveUnit(a, b, 1'b0);
        checks++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0)
            $display("[TB] FAIL %s done: done=%b busy=%b, expected done=1 busy=0 at cycle %0d", name, bus.done, bus.busy, lat + 1);
        else passed++;
        checks++;
        if (bus.result !== expRes || {bus.flag_n, bus.flag_z, bus.flag_v, bus.flag_c} !== expFlags)
            $display("[TB] FAIL %s result: result=%h nzvc=%b, expected result=%h nzvc=%b", name,
                     bus.result, {bus.flag_n, bus.flag_z, bus.flag_v, bus.flag_c}, expRes, expFlags);
        else passed++;
        prevRes   = expRes;
        prevFlags = expFlags;
    endtask

    task automatic divZero(input logic [1:0] op, input logic [31:0] a, input string name);
        bus.start = 1'b1;
        bus.op    = op;
        bus.src_a = a;
        bus.src_b = 16'h0;
        @(posedge clock); #1;
        bus.start = 1'b0;
        checks++;
        if (bus.div_zero !== 1'b1 || bus.busy !== 1'b0)
            $display("[TB] FAIL %s trap: div_zero=%b busy=%b, expected div_zero=1 busy=0", name, bus.div_zero, bus.busy);
        else passed++;
        @(posedge clock); #1;
        checks++;
        if (bus.div_zero !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== prevRes ||
            {bus.flag_n, bus.flag_z, bus.flag_v, bus.flag_c} !== prevFlags)
            $display("[TB] FAIL %s after: div_zero=%b busy=%b done=%b result=%h, expected 0 0 0 result=%h",
                     name, bus.div_zero, bus.busy, bus.done, bus.result, prevRes);
        else passed++;
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.div_zero !== 1'b0)
            $display("[TB] FAIL reset ctrl: busy=%b done=%b div_zero=%b, expected all 0", bus.busy, bus.done, bus.div_zero);
        else passed++;
        checks++;
        if (bus.result !== 32'h0 || {bus.flag_n, bus.flag_z, bus.flag_v, bus.flag_c} !== 4'b0000)
            $display("[TB] FAIL reset result: result=%h nzvc=%b, expected 0", bus.result, {bus.flag_n, bus.flag_z, bus.flag_v, bus.flag_c});
        else passed++;
        checks++;
        if (bus.operand1 !== 32'h0 || bus.operand2 !== 32'h0)
            $display("[TB] FAIL reset operands: op1=%h op2=%h, expected 0", bus.operand1, bus.operand2);
        else passed++;
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic test_directed;
        logic [1:0]  ops  [5] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b10};
        logic [31:0] as   [5] = '{32'h00000003, 32'h0000FFFF, 32'd100, 32'hFFFFFFF9, 32'h00100000};
        logic [15:0] bs   [5] = '{16'h0004, 16'h0002, 16'd7, 16'h0002, 16'h0001};
        logic [31:0] rs   [5] = '{32'h0000000C, 32'hFFFFFFFE, 32'h0002000E, 32'hFFFFFFFD, 32'h00100000};
        logic [3:0]  fs   [5] = '{4'b0000, 4'b1000, 4'b0000, 4'b1000, 4'b0010};
        for (int i = 0; i < 5; i++) begin
            runOp(ops[i], as[i], bs[i], 1'b0, "directed");
            checks++;
            if (bus.result !== rs[i] || {bus.flag_n, bus.flag_z, bus.flag_v, bus.flag_c} !== fs[i])
                $display("[TB] FAIL directed%0d: result=%h nzvc=%b, expected result=%h nzvc=%b", i,
                         bus.result, {bus.flag_n, bus.flag_z, bus.flag_v, bus.flag_c}, rs[i], fs[i]);
            else passed++;
            @(posedge clock); #1;
        end
    endtask

    task automatic test_div_zero;
        divZero(2'b10, 32'h12345678, "divu_zero");
        divZero(2'b11, 32'h80000000, "divs_zero");
    endtask

    task automatic test_random;
        logic [1:0]  op;
        logic [31:0] a;
        logic [15:0] b;
        for (int i = 0; i < 24; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            if ($urandom_range(0, 1) == 1) a = a >> $urandom_range(8, 20);
            b  = 16'($urandom);
            if ($urandom_range(0, 7) == 0) b = 16'h0;
            if (op[1] && b == 16'h0) divZero(op, a, "random_zero");
            else runOp(op, a, b, 1'b0, "random");
        end
    endtask

    task automatic test_back_to_back;
        runOp(2'b01, 32'h00008000, 16'h7FFF, 1'b0, "b2b_muls");
        runOp(2'b11, 32'h7FFFFFFF, 16'hFFFF, 1'b0, "b2b_divs_ovf");
        runOp(2'b00, 32'hABCD0000, 16'h1234, 1'b0, "b2b_mulu_zero");
        runOp(2'b11, 32'hFFFF8000, 16'h0001, 1'b0, "b2b_divs_min");
    endtask

    task automatic test_ignore_start;
        runOp(2'b00, 32'h0000FFFF, 16'hFFFF, 1'b1, "ignore_start");
        @(posedge clock); #1;
    endtask

    task automatic test_reset_mid;
        bit bad;
        bus.start = 1'b1;
        bus.op    = 2'b10;
        bus.src_a = 32'd1000;
        bus.src_b = 16'd3;
        @(posedge clock); #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 32'h0 || bus.operand1 !== 32'h0 ||
            {bus.flag_n, bus.flag_z, bus.flag_v, bus.flag_c} !== 4'b0000)
            $display("[TB] FAIL reset_mid clear: busy=%b done=%b result=%h op1=%h, expected all 0",
                     bus.busy, bus.done, bus.result, bus.operand1);
        else passed++;
        @(negedge clock);
        reset = 1'b1;
        prevRes   = 32'h0;
        prevFlags = 4'b0000;
        bad = 1'b0;
        repeat (40) begin
            @(posedge clock); #1;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) $display("[TB] FAIL reset_mid quiet: done or busy seen after reset, expected none");
        else passed++;
    endtask

`ifdef MULDIV_ABORT_EN
    task automatic abortAt(input logic [1:0] op, input logic [31:0] a, input logic [15:0] b,
                           input int abortEdge, input string name);
        bit bad;
        bus.start = 1'b1;
        bus.op    = op;
        bus.src_a = a;
        bus.src_b = b;
        @(posedge clock); #1;
        bus.start = 1'b0;
        repeat (abortEdge - 1) @(posedge clock);
        #1;
        bus.abort = 1'b1;
        driveUnit(a, b, 1'b1);
        @(posedge clock); #1;
        bus.abort = 1'b0;
        driveUnit(a, b, 1'b0);
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0)
            $display("[TB] FAIL %s stop: busy=%b done=%b, expected 0 0", name, bus.busy, bus.done);
        else passed++;
        bad = 1'b0;
        repeat (35) begin
            @(posedge clock); #1;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad || bus.result !== prevRes || {bus.flag_n, bus.flag_z, bus.flag_v, bus.flag_c} !== prevFlags)
            $display("[TB] FAIL %s quiet: late activity=%b result=%h, expected 0 result=%h", name, bad, bus.result, prevRes);
        else passed++;
    endtask

    task automatic test_abort;
        abortAt(2'b10, 32'd5000, 16'd9, 5, "abort_c5");
        abortAt(2'b00, 32'h00001234, 16'h0042, MUL_LAT + 1, "abort_final");
    endtask
`endif

    initial begin
        reset     = 1'b0;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.src_a = 32'h0;
        bus.src_b = 16'h0;
`ifdef MULDIV_ABORT_EN
        bus.abort = 1'b0;
`endif
        prevRes   = 32'h0;
        prevFlags = 4'b0000;
        driveUnit(32'h0, 16'h0, 1'b0);
        $display("[TB] muldiv_sequencer bench start");
        test_reset();
        test_directed();
        test_div_zero();
        test_random();
        test_back_to_back();
        test_ignore_start();
        test_reset_mid();
`ifdef MULDIV_ABORT_EN
        test_abort();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
